// File: rtl/uart_tx_scheduler_if.sv
// Requester-side handshake and TX-path launch/completion signals of the
// shared UART transmit scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      baud_tick;
  logic                      tx_done;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;

  // Client/TX-path side: drives requests, ticks and completion.
  modport master (
    output req_valid, req_data, baud_tick, tx_done,
    input  req_ready, tx_start, tx_data
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, baud_tick, tx_done,
    output req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX path among NUM_REQ byte
// requesters: accept one byte, launch a frame, wait for completion with a
// baud-tick timeout, then hold the line idle for an inter-frame gap.
module uart_tx_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 16,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clock,
  input  logic                reset,
  uart_tx_scheduler_if.slave  bus,
  output logic [ID_W-1:0]     grant_id,
  output logic                active,
  output logic                timeout_err,
  output logic [7:0]          err_count
);

  localparam int MAX_T = (TIMEOUT_TICKS > GAP_TICKS) ? TIMEOUT_TICKS : GAP_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    SEND,
    GAP
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]   to_cnt;
  logic [CNT_W-1:0]   gap_cnt;

  logic               found;
  logic [ID_W-1:0]    sel;
  logic [ID_W-1:0]    next_ptr;
  logic [ID_W:0]      sum;
  logic [DATA_W-1:0]  sel_data;

  // Round-robin search: first pending requester starting at rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (!found && bus.req_valid[sum[ID_W-1:0]]) begin
        found = 1'b1;
        sel   = sum[ID_W-1:0];
      end
    end
  end

  // Pointer successor of the selected requester and its payload byte.
  always_comb begin
    next_ptr = (sel == ID_LAST) ? '0 : sel + 1'b1;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == sel) sel_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Accept strobe: only in IDLE, one-hot on the selected requester; masked
  // during reset so no handshake can complete while the block is held.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && found && !reset) bus.req_ready[sel] = 1'b1;
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      to_cnt       <= '0;
      gap_cnt      <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= '0;
      grant_id     <= '0;
      active       <= 1'b0;
      timeout_err  <= 1'b0;
      err_count    <= '0;
    end else begin
      bus.tx_start <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.tx_data  <= sel_data;
            grant_id     <= sel;
            rr_ptr       <= next_ptr;
            bus.tx_start <= 1'b1;
            active       <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          to_cnt <= '0;
          state  <= SEND;
        end
        SEND: begin
          // Completion takes priority over a coincident terminal tick.
          if (bus.tx_done) begin
            active <= 1'b0;
            state  <= GAP;
          end else if (bus.baud_tick) begin
            if (to_cnt == TO_LAST) begin
              timeout_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              active <= 1'b0;
              state  <= GAP;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (GAP_TICKS == 0) begin
            state <= IDLE;
          end else if (bus.baud_tick) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              state   <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (4 requesters, 8-bit
// data, 2-tick gap, 16-tick timeout).
module tb_uart_tx_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant_id;
  logic       active;
  logic       timeout_err;
  logic [7:0] err_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  uart_tx_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ(4),
    .DATA_W(8),
    .GAP_TICKS(2),
    .TIMEOUT_TICKS(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .grant_id(grant_id),
    .active(active),
    .timeout_err(timeout_err),
    .err_count(err_count)
  );

  // Observe state from the previous edge, then apply inputs for the next one.
  task automatic drive(input logic [3:0] v, input logic bt, input logic dn);
    @(negedge clock);
    bus.req_valid = v;
    bus.baud_tick = bt;
    bus.tx_done   = dn;
    #1;
  endtask

  task automatic set_data(input logic [7:0] d3, input logic [7:0] d2,
                          input logic [7:0] d1, input logic [7:0] d0);
    bus.req_data = {d3, d2, d1, d0};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // Called while observing LAUNCH: done in SEND, then two gap ticks.
  task automatic close_frame(input logic [3:0] v);
    drive(v, 1'b0, 1'b1);
    drive(v, 1'b1, 1'b0);
    drive(v, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
    vectors++; if (bus.tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %b expected 0", active); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    drive(4'b0010, 1'b0, 1'b0);
    vectors++; if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL single_ready: got %b expected 0010", bus.req_ready); end
    drive(4'b0000, 1'b0, 1'b0);
    vectors++; if (bus.tx_start !== 1'b1) begin miscompares++; $display("FAIL single_tx_start: got %b expected 1", bus.tx_start); end
    vectors++; if (bus.tx_data !== 8'hA5) begin miscompares++; $display("FAIL single_tx_data: got %h expected a5", bus.tx_data); end
    vectors++; if (grant_id !== 2'd1) begin miscompares++; $display("FAIL single_grant_id: got %0d expected 1", grant_id); end
    vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL single_active_launch: got %b expected 1", active); end
    drive(4'b0000, 1'b1, 1'b0);
    vectors++; if (bus.tx_start !== 1'b0) begin miscompares++; $display("FAIL single_start_pulse: got %b expected 0", bus.tx_start); end
    repeat (10) drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 1'b0, 1'b1);
    vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL single_active_send: got %b expected 1", active); end
    drive(4'b0100, 1'b1, 1'b0);
    vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL single_active_gap: got %b expected 0", active); end
    vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL single_gap_ready1: got %b expected 0000", bus.req_ready); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL single_no_timeout: got %b expected 0", timeout_err); end
    vectors++; if (bus.tx_data !== 8'hA5 || grant_id !== 2'd1) begin miscompares++; $display("FAIL single_hold: got %h/%0d expected a5/1", bus.tx_data, grant_id); end
    drive(4'b0100, 1'b1, 1'b0);
    vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL single_gap_ready2: got %b expected 0000", bus.req_ready); end
    drive(4'b0100, 1'b0, 1'b0);
    vectors++; if (bus.req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_after_gap_ready: got %b expected 0100", bus.req_ready); end
    drive(4'b0000, 1'b0, 1'b0);
    vectors++; if (grant_id !== 2'd2) begin miscompares++; $display("FAIL single_second_grant: got %0d expected 2", grant_id); end
    close_frame(4'b0000);
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    do_reset();
    set_data(8'h13, 8'h12, 8'h11, 8'h10);
    for (int k = 0; k < 5; k++) begin
      exp_id  = 2'(k % 4);
      exp_rdy = 4'b0001 << exp_id;
      drive(4'b1111, 1'b0, 1'b0);
      vectors++; if (bus.req_ready !== exp_rdy) begin miscompares++; $display("FAIL fair_ready[%0d]: got %b expected %b", k, bus.req_ready, exp_rdy); end
      drive(4'b1111, 1'b0, 1'b0);
      vectors++; if (bus.tx_start !== 1'b1 || grant_id !== exp_id) begin miscompares++; $display("FAIL fair_grant[%0d]: got start=%b id=%0d expected start=1 id=%0d", k, bus.tx_start, grant_id, exp_id); end
      vectors++; if (bus.tx_data !== 8'h10 + 8'(exp_id)) begin miscompares++; $display("FAIL fair_data[%0d]: got %h expected %h", k, bus.tx_data, 8'h10 + 8'(exp_id)); end
      close_frame(4'b1111);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_data(8'h00, 8'hC2, 8'h00, 8'h00);
    drive(4'b0100, 1'b0, 1'b0);
    vectors++; if (bus.req_ready !== 4'b0100) begin miscompares++; $display("FAIL wrap_ready2: got %b expected 0100", bus.req_ready); end
    drive(4'b0000, 1'b0, 1'b0);
    vectors++; if (grant_id !== 2'd2) begin miscompares++; $display("FAIL wrap_grant2: got %0d expected 2", grant_id); end
    close_frame(4'b0000);
    set_data(8'hD3, 8'h00, 8'h00, 8'hD0);
    drive(4'b1001, 1'b0, 1'b0);
    vectors++; if (bus.req_ready !== 4'b1000) begin miscompares++; $display("FAIL wrap_ready3: got %b expected 1000", bus.req_ready); end
    drive(4'b1001, 1'b0, 1'b0);
    vectors++; if (grant_id !== 2'd3 || bus.tx_data !== 8'hD3) begin miscompares++; $display("FAIL wrap_grant3: got %0d/%h expected 3/d3", grant_id, bus.tx_data); end
    close_frame(4'b1001);
    drive(4'b1001, 1'b0, 1'b0);
    vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL wrap_ready0: got %b expected 0001", bus.req_ready); end
    drive(4'b0000, 1'b0, 1'b0);
    vectors++; if (grant_id !== 2'd0 || bus.tx_data !== 8'hD0) begin miscompares++; $display("FAIL wrap_grant0: got %0d/%h expected 0/d0", grant_id, bus.tx_data); end
    close_frame(4'b0000);
  endtask

  task automatic test_timeout();
    logic [7:0] exp_cnt;
    do_reset();
    set_data(8'h00, 8'h00, 8'h00, 8'h77);
    for (int n = 1; n <= 300; n++) begin
      exp_cnt = (n > 255) ? 8'd255 : 8'(n);
      drive(4'b0001, 1'b0, 1'b0);
      drive(4'b0000, 1'b0, 1'b0);
      repeat (15) drive(4'b0000, 1'b1, 1'b0);
      drive(4'b0000, 1'b1, 1'b0);
      if (n == 1) begin
        vectors++; if (timeout_err !== 1'b0 || active !== 1'b1) begin miscompares++; $display("FAIL timeout_early: got err=%b active=%b expected err=0 active=1", timeout_err, active); end
      end
      drive(4'b0000, 1'b0, 1'b0);
      vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL timeout_pulse[%0d]: got %b expected 1", n, timeout_err); end
      vectors++; if (err_count !== exp_cnt) begin miscompares++; $display("FAIL timeout_count[%0d]: got %0d expected %0d", n, err_count, exp_cnt); end
      drive(4'b0000, 1'b1, 1'b0);
      if (n == 1) begin
        vectors++; if (timeout_err !== 1'b0 || active !== 1'b0) begin miscompares++; $display("FAIL timeout_one_cycle: got err=%b active=%b expected err=0 active=0", timeout_err, active); end
      end
      drive(4'b0000, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    set_data(8'h00, 8'h00, 8'h3C, 8'h4B);
    drive(4'b0010, 1'b0, 1'b0);
    vectors++; if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL rmid_ready: got %b expected 0010", bus.req_ready); end
    drive(4'b0000, 1'b0, 1'b0);
    vectors++; if (grant_id !== 2'd1 || bus.tx_data !== 8'h3C) begin miscompares++; $display("FAIL rmid_grant: got %0d/%h expected 1/3c", grant_id, bus.tx_data); end
    repeat (3) drive(4'b0000, 1'b1, 1'b0);
    reset = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    reset = 1'b0;
    vectors++; if (bus.tx_data !== 8'h00 || grant_id !== 2'd0) begin miscompares++; $display("FAIL rmid_data_id: got %h/%0d expected 00/0", bus.tx_data, grant_id); end
    vectors++; if (active !== 1'b0 || bus.tx_start !== 1'b0) begin miscompares++; $display("FAIL rmid_active_start: got %b/%b expected 0/0", active, bus.tx_start); end
    vectors++; if (timeout_err !== 1'b0 || err_count !== 8'd0) begin miscompares++; $display("FAIL rmid_err: got %b/%0d expected 0/0", timeout_err, err_count); end
    drive(4'b1111, 1'b0, 1'b0);
    vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL rmid_restart_ready: got %b expected 0001", bus.req_ready); end
    drive(4'b0000, 1'b0, 1'b0);
    vectors++; if (grant_id !== 2'd0 || bus.tx_data !== 8'h4B || bus.tx_start !== 1'b1) begin miscompares++; $display("FAIL rmid_restart_grant: got %0d/%h/%b expected 0/4b/1", grant_id, bus.tx_data, bus.tx_start); end
    close_frame(4'b0000);
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_data(8'h00, 8'h00, 8'h66, 8'h55);
    drive(4'b0001, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    repeat (15) drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b1);
    drive(4'b0100, 1'b0, 1'b0);
    vectors++; if (timeout_err !== 1'b0 || err_count !== 8'd0) begin miscompares++; $display("FAIL simul_done_wins: got %b/%0d expected 0/0", timeout_err, err_count); end
    vectors++; if (active !== 1'b0 || bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL simul_gap: got active=%b ready=%b expected 0/0000", active, bus.req_ready); end
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 1'b0, 1'b1);
    vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL simul_dropped_ready: got %b expected 0000", bus.req_ready); end
    drive(4'b0000, 1'b0, 1'b0);
    vectors++; if (active !== 1'b0 || bus.tx_start !== 1'b0 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL simul_no_grant: got %b/%b/%b expected 0/0/0", active, bus.tx_start, timeout_err); end
    drive(4'b1111, 1'b0, 1'b0);
    vectors++; if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL simul_ptr_kept: got %b expected 0010", bus.req_ready); end
    drive(4'b0000, 1'b0, 1'b0);
    vectors++; if (grant_id !== 2'd1 || bus.tx_data !== 8'h66) begin miscompares++; $display("FAIL simul_next_grant: got %0d/%h expected 1/66", grant_id, bus.tx_data); end
    close_frame(4'b0000);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.baud_tick = 1'b0;
    bus.tx_done   = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
